// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package ifu_pkg;

    typedef enum logic [1:0] {StIdle, StAr, StRdata, StDrain} ifu_state_e;

    // Field widths of the default RV32 configuration; wider builds define their own entry type.
    localparam int unsigned IFU_ADDR_W = 32;
    localparam int unsigned IFU_INST_W = 32;

    typedef struct packed {
        logic [IFU_INST_W-1:0] inst;
        logic [IFU_ADDR_W-1:0] pc;
        logic                  exception;
    } fetch_entry_t;

    localparam logic [3:0] MCAUSE_INST_ACCESS_FAULT = 4'd1;
    localparam logic [1:0] AXI_BURST_INCR           = 2'b01;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO of fetch entries; clear overrides push and pop in the same cycle.
module ifu_fifo #(
    parameter int unsigned Depth = 8,
    parameter type entry_t = ifu_pkg::fetch_entry_t
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  clear_i,
    input  entry_t                wdata_i,
    output entry_t                rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth) + 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    entry_t            mem_q [Depth];
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [CntW-1:0]   count_q;
    logic              do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FullCnt);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // A pop frees the slot the same cycle, so a full FIFO may still accept a push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);
            end
            if (do_push != do_pop) begin
                count_q <= do_push ? count_q + CntW'(1) : count_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/ifu_prefetch_queue.sv
// Sequential instruction prefetcher: AXI4 INCR line bursts into a FIFO, one instruction per cycle
// to decode, with redirect draining and access-fault reporting.
module ifu_prefetch_queue
    import ifu_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       INST_W    = 32,
    parameter int unsigned       BURST_LEN = 4,
    parameter int unsigned       DEPTH     = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(32'h3000_0000),
    parameter logic [3:0]        AXI_ID    = 4'd0
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [INST_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_exception,
    output logic [3:0]        o_mcause,
    output logic              o_arvalid,
    input  logic              i_arready,
    output logic [ADDR_W-1:0] o_araddr,
    output logic [7:0]        o_arlen,
    output logic [2:0]        o_arsize,
    output logic [1:0]        o_arburst,
    output logic [3:0]        o_arid,
    input  logic              i_rvalid,
    output logic              o_rready,
    input  logic [INST_W-1:0] i_rdata,
    input  logic [1:0]        i_rresp,
    input  logic              i_rlast,
    input  logic [3:0]        i_rid
);

    localparam int unsigned       BEAT_BYTES = INST_W / 8;
    localparam int unsigned       LINE_BYTES = BURST_LEN * BEAT_BYTES;
    localparam int unsigned       CNT_W      = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  MAX_FILL   = CNT_W'(DEPTH - BURST_LEN);
    localparam logic [ADDR_W-1:0] BEAT_STEP  = ADDR_W'(BEAT_BYTES);
    localparam logic [ADDR_W-1:0] LINE_STEP  = ADDR_W'(LINE_BYTES);
    localparam logic [ADDR_W-1:0] LINE_MASK  = ~(LINE_STEP - ADDR_W'(1));

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
        logic              exception;
    } entry_t;

    ifu_state_e        state_q;
    logic [ADDR_W-1:0] fetch_pc_q, base_q, beat_addr_q;
    logic              halted_q, drain_q, fault_q;

    entry_t            wr_entry, head;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              beat_fault;
    logic              unused_ok;

    assign beat_fault = (i_rresp != 2'b00);
    // Leading beats below fetch_pc belong to an unaligned redirect and are dropped.
    assign fifo_push  = (state_q == StRdata) && i_rvalid && !i_flush && (beat_addr_q >= fetch_pc_q);
    assign fifo_pop   = o_valid && i_ready;

    assign wr_entry.inst      = beat_fault ? '0 : i_rdata;
    assign wr_entry.pc        = beat_addr_q;
    assign wr_entry.exception = beat_fault;

    ifu_fifo #(
        .Depth   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i   (i_clock),
        .rst_ni  (i_reset_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .clear_i (i_flush),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= StIdle;
            fetch_pc_q  <= RESET_PC;
            base_q      <= '0;
            beat_addr_q <= '0;
            halted_q    <= 1'b0;
            drain_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!halted_q && !i_flush && (fifo_count <= MAX_FILL)) begin
                        state_q     <= StAr;
                        base_q      <= fetch_pc_q & LINE_MASK;
                        beat_addr_q <= fetch_pc_q & LINE_MASK;
                        drain_q     <= 1'b0;
                        fault_q     <= 1'b0;
                    end
                end
                StAr: begin
                    if (i_flush) begin
                        drain_q <= 1'b1;
                    end
                    if (i_arready) begin
                        state_q <= (drain_q || i_flush) ? StDrain : StRdata;
                    end
                end
                StRdata: begin
                    if (i_rvalid) begin
                        beat_addr_q <= beat_addr_q + BEAT_STEP;
                        if (fifo_push && beat_fault) begin
                            fault_q <= 1'b1;
                        end
                    end
                    if (i_rvalid && i_rlast) begin
                        state_q    <= StIdle;
                        fetch_pc_q <= base_q + LINE_STEP;
                        if (fault_q || (fifo_push && beat_fault)) begin
                            halted_q <= 1'b1;
                        end
                    end else if (i_flush) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (i_rvalid && i_rlast) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
            // Redirect overrides the sequential fetch_pc advance and releases a fault halt.
            if (i_flush) begin
                fetch_pc_q <= i_redirect_pc;
                halted_q   <= 1'b0;
            end
        end
    end

    assign o_arvalid = (state_q == StAr);
    assign o_araddr  = base_q;
    assign o_arlen   = 8'(BURST_LEN - 1);
    assign o_arsize  = 3'($clog2(BEAT_BYTES));
    assign o_arburst = AXI_BURST_INCR;
    assign o_arid    = AXI_ID;
    assign o_rready  = (state_q == StRdata) || (state_q == StDrain);

    assign o_valid     = !fifo_empty;
    assign o_inst      = o_valid ? head.inst : '0;
    assign o_pc        = o_valid ? head.pc : '0;
    assign o_exception = o_valid && head.exception;
    assign o_mcause    = o_exception ? MCAUSE_INST_ACCESS_FAULT : 4'd0;

    assign unused_ok = ^{i_rid, fifo_full};

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Directed bench for ifu_prefetch_queue with default parameters and a scripted AXI read slave.
module tb_ifu_prefetch_queue;

    logic        clk = 1'b0;
    logic        i_reset_n, i_flush, i_ready, i_arready, i_rvalid, i_rlast;
    logic [31:0] i_redirect_pc, i_rdata;
    logic [1:0]  i_rresp;
    logic [3:0]  i_rid;
    logic        o_valid, o_exception, o_arvalid, o_rready;
    logic [31:0] o_inst, o_pc, o_araddr;
    logic [3:0]  o_mcause, o_arid;
    logic [7:0]  o_arlen;
    logic [2:0]  o_arsize;
    logic [1:0]  o_arburst;

    int errors = 0;
    int checks = 0;

    logic [31:0] mon_pc[$];
    logic [31:0] mon_inst[$];
    logic        mon_exc[$];
    logic [3:0]  mon_mcause[$];

    always #5 clk = ~clk;

    ifu_prefetch_queue dut (
        .i_clock       (clk),
        .i_reset_n     (i_reset_n),
        .i_flush       (i_flush),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_inst        (o_inst),
        .o_pc          (o_pc),
        .o_exception   (o_exception),
        .o_mcause      (o_mcause),
        .o_arvalid     (o_arvalid),
        .i_arready     (i_arready),
        .o_araddr      (o_araddr),
        .o_arlen       (o_arlen),
        .o_arsize      (o_arsize),
        .o_arburst     (o_arburst),
        .o_arid        (o_arid),
        .i_rvalid      (i_rvalid),
        .o_rready      (o_rready),
        .i_rdata       (i_rdata),
        .i_rresp       (i_rresp),
        .i_rlast       (i_rlast),
        .i_rid         (i_rid)
    );

    // Consumer-side record of every accepted instruction.
    always @(negedge clk) begin
        if (i_reset_n && o_valid && i_ready && !i_flush) begin
            mon_pc.push_back(o_pc);
            mon_inst.push_back(o_inst);
            mon_exc.push_back(o_exception);
            mon_mcause.push_back(o_mcause);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_pc.delete();
        mon_inst.delete();
        mon_exc.delete();
        mon_mcause.delete();
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0; i_flush = 1'b0; i_redirect_pc = '0; i_ready = 1'b0;
        i_arready = 1'b0; i_rvalid = 1'b0; i_rdata = '0; i_rresp = '0; i_rlast = 1'b0;
        i_rid = '0;
        repeat (3) step();
        i_reset_n = 1'b1;
        clear_mon();
    endtask

    task automatic wait_ar(output logic [31:0] addr, output bit ok);
        ok = 1'b0;
        addr = '0;
        for (int i = 0; i < 64; i++) begin
            if (o_arvalid) begin
                ok = 1'b1;
                addr = o_araddr;
                break;
            end
            step();
        end
    endtask

    task automatic ar_accept();
        i_arready = 1'b1;
        step();
        i_arready = 1'b0;
    endtask

    // Slave data for a good beat is the bitwise inverse of its address.
    task automatic send_beat(input logic [31:0] addr, input logic [1:0] resp, input logic last);
        i_rvalid = 1'b1;
        i_rdata  = (resp != 2'b00) ? 32'hDEAD_BEEF : ~addr;
        i_rresp  = resp;
        i_rlast  = last;
        step();
        i_rvalid = 1'b0;
        i_rlast  = 1'b0;
        i_rresp  = 2'b00;
    endtask

    task automatic send_burst(input logic [31:0] base, input int fault_idx);
        for (int k = 0; k < 4; k++) begin
            send_beat(base + 32'(4 * k), (k == fault_idx) ? 2'b10 : 2'b00, k == 3);
        end
    endtask

    task automatic test_reset();
        do_reset();
        i_reset_n = 1'b0;
        step();
        checks++;
        if ({o_valid, o_arvalid, o_rready, o_exception} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000", {o_valid, o_arvalid, o_rready, o_exception});
        end
        checks++;
        if ({o_inst, o_pc, o_mcause} !== 68'h0) begin
            errors++;
            $display("FAIL reset_data: got inst=%h pc=%h mcause=%h expected zeros", o_inst, o_pc, o_mcause);
        end
        i_reset_n = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        bit ok;
        do_reset();
        i_ready = 1'b1;
        wait_ar(a, ok);
        checks++;
        if (!ok || a !== 32'h3000_0000) begin
            errors++; $display("FAIL seq_ar0: got %h ok=%0d expected 30000000", a, ok);
        end
        checks++;
        if ({o_arlen, o_arsize, o_arburst, o_arid} !== {8'd3, 3'd2, 2'b01, 4'd0}) begin
            errors++;
            $display("FAIL seq_arctl: got len=%h size=%h burst=%h id=%h expected 3 2 1 0",
                     o_arlen, o_arsize, o_arburst, o_arid);
        end
        ar_accept();
        send_burst(32'h3000_0000, -1);
        repeat (2) step();
        checks++;
        if (mon_pc.size() != 4) begin
            errors++; $display("FAIL seq_count: got %0d expected 4", mon_pc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (mon_pc[k] !== 32'h3000_0000 + 32'(4 * k) || mon_inst[k] !== ~mon_pc[k]
                    || mon_exc[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL seq_entry%0d: got pc=%h inst=%h exc=%b expected pc=%h inst=%h exc=0",
                             k, mon_pc[k], mon_inst[k], mon_exc[k], 32'h3000_0000 + 32'(4 * k),
                             ~(32'h3000_0000 + 32'(4 * k)));
                end
            end
        end
        wait_ar(a, ok);
        checks++;
        if (!ok || a !== 32'h3000_0010) begin
            errors++; $display("FAIL seq_ar1: got %h ok=%0d expected 30000010", a, ok);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a;
        bit ok;
        int ar_seen;
        do_reset();
        for (int b = 0; b < 2; b++) begin
            wait_ar(a, ok);
            checks++;
            if (!ok || a !== 32'h3000_0000 + 32'(16 * b)) begin
                errors++;
                $display("FAIL bp_ar%0d: got %h ok=%0d expected %h", b, a, ok, 32'h3000_0000 + 32'(16 * b));
            end
            ar_accept();
            send_burst(32'h3000_0000 + 32'(16 * b), -1);
        end
        ar_seen = 0;
        repeat (10) begin
            step();
            if (o_arvalid) ar_seen++;
        end
        checks++;
        if (ar_seen != 0 || o_valid !== 1'b1 || o_pc !== 32'h3000_0000) begin
            errors++;
            $display("FAIL bp_full: got ar_cycles=%0d valid=%b pc=%h expected 0 1 30000000",
                     ar_seen, o_valid, o_pc);
        end
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        ar_seen = 0;
        repeat (10) begin
            step();
            if (o_arvalid) ar_seen++;
        end
        checks++;
        if (ar_seen != 0 || o_pc !== 32'h3000_0004) begin
            errors++;
            $display("FAIL bp_pop1: got ar_cycles=%0d pc=%h expected 0 30000004", ar_seen, o_pc);
        end
        i_ready = 1'b1;
        repeat (3) step();
        i_ready = 1'b0;
        checks++;
        if (o_pc !== 32'h3000_0010) begin
            errors++; $display("FAIL bp_head: got %h expected 30000010", o_pc);
        end
        wait_ar(a, ok);
        checks++;
        if (!ok || a !== 32'h3000_0020) begin
            errors++; $display("FAIL bp_ar2: got %h ok=%0d expected 30000020", a, ok);
        end
    endtask

    task automatic test_flush_mid_burst();
        logic [31:0] a;
        bit ok;
        int bad;
        do_reset();
        i_ready = 1'b1;
        wait_ar(a, ok);
        ar_accept();
        send_beat(32'h3000_0000, 2'b00, 1'b0);
        send_beat(32'h3000_0004, 2'b00, 1'b0);
        // Redirect lands together with beat 2.
        i_flush = 1'b1;
        i_redirect_pc = 32'h8000_0008;
        i_rvalid = 1'b1;
        i_rdata = ~32'h3000_0008;
        i_rlast = 1'b0;
        step();
        i_flush = 1'b0;
        i_rvalid = 1'b0;
        clear_mon();
        bad = 0;
        if (o_valid !== 1'b0 || o_rready !== 1'b1) bad++;
        i_rvalid = 1'b1;
        i_rdata = ~32'h3000_000C;
        i_rlast = 1'b1;
        #4;
        if (o_valid !== 1'b0) bad++;
        step();
        i_rvalid = 1'b0;
        i_rlast = 1'b0;
        checks++;
        if (bad != 0 || mon_pc.size() != 0) begin
            errors++;
            $display("FAIL fl_drain: got bad_cycles=%0d pops=%0d expected 0 0", bad, mon_pc.size());
        end
        wait_ar(a, ok);
        checks++;
        if (!ok || a !== 32'h8000_0000) begin
            errors++; $display("FAIL fl_ar: got %h ok=%0d expected 80000000", a, ok);
        end
        ar_accept();
        send_burst(32'h8000_0000, -1);
        repeat (2) step();
        checks++;
        if (mon_pc.size() != 2) begin
            errors++; $display("FAIL fl_count: got %0d expected 2", mon_pc.size());
        end else begin
            checks++;
            if (mon_pc[0] !== 32'h8000_0008 || mon_pc[1] !== 32'h8000_000C
                || mon_inst[0] !== 32'h7FFF_FFF7) begin
                errors++;
                $display("FAIL fl_pcs: got %h %h inst=%h expected 80000008 8000000c inst=7ffffff7",
                         mon_pc[0], mon_pc[1], mon_inst[0]);
            end
        end
    endtask

    task automatic test_flush_in_ar();
        logic [31:0] a;
        bit ok;
        do_reset();
        i_ready = 1'b1;
        wait_ar(a, ok);
        i_flush = 1'b1;
        i_redirect_pc = 32'h8000_0104;
        step();
        i_flush = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (o_arvalid !== 1'b1 || o_araddr !== 32'h3000_0000) begin
                errors++;
                $display("FAIL ar_hold%0d: got arvalid=%b addr=%h expected 1 30000000", c, o_arvalid, o_araddr);
            end
            step();
        end
        checks++;
        if (o_arvalid !== 1'b1 || o_araddr !== 32'h3000_0000) begin
            errors++;
            $display("FAIL ar_hold2: got arvalid=%b addr=%h expected 1 30000000", o_arvalid, o_araddr);
        end
        ar_accept();
        send_burst(32'h3000_0000, -1);
        repeat (2) step();
        checks++;
        if (o_valid !== 1'b0 || mon_pc.size() != 0) begin
            errors++;
            $display("FAIL ar_discard: got valid=%b pops=%0d expected 0 0", o_valid, mon_pc.size());
        end
        wait_ar(a, ok);
        checks++;
        if (!ok || a !== 32'h8000_0100) begin
            errors++; $display("FAIL ar_redirect: got %h ok=%0d expected 80000100", a, ok);
        end
        ar_accept();
        send_burst(32'h8000_0100, -1);
        repeat (2) step();
        checks++;
        if (mon_pc.size() != 3 || mon_pc[0] !== 32'h8000_0104) begin
            errors++;
            $display("FAIL ar_entries: got count=%0d first=%h expected 3 80000104",
                     mon_pc.size(), (mon_pc.size() > 0) ? mon_pc[0] : 32'h0);
        end
    endtask

    task automatic test_fault();
        logic [31:0] a;
        bit ok;
        int ar_seen;
        do_reset();
        i_ready = 1'b1;
        wait_ar(a, ok);
        ar_accept();
        send_burst(32'h3000_0000, 2);
        repeat (2) step();
        checks++;
        if (mon_pc.size() != 4) begin
            errors++; $display("FAIL flt_count: got %0d expected 4", mon_pc.size());
        end else begin
            checks++;
            if (mon_pc[2] !== 32'h3000_0008 || mon_exc[2] !== 1'b1 || mon_mcause[2] !== 4'd1
                || mon_inst[2] !== 32'h0) begin
                errors++;
                $display("FAIL flt_entry: got pc=%h exc=%b mcause=%h inst=%h expected 30000008 1 1 0",
                         mon_pc[2], mon_exc[2], mon_mcause[2], mon_inst[2]);
            end
            checks++;
            if (mon_exc[1] !== 1'b0 || mon_mcause[1] !== 4'd0) begin
                errors++;
                $display("FAIL flt_clean: got exc=%b mcause=%h expected 0 0", mon_exc[1], mon_mcause[1]);
            end
        end
        ar_seen = 0;
        repeat (20) begin
            step();
            if (o_arvalid) ar_seen++;
        end
        checks++;
        if (ar_seen != 0) begin
            errors++; $display("FAIL flt_halt: got ar_cycles=%0d expected 0", ar_seen);
        end
        i_flush = 1'b1;
        i_redirect_pc = 32'h3000_0100;
        step();
        i_flush = 1'b0;
        wait_ar(a, ok);
        checks++;
        if (!ok || a !== 32'h3000_0100) begin
            errors++; $display("FAIL flt_resume: got %h ok=%0d expected 30000100", a, ok);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] a;
        bit ok;
        do_reset();
        wait_ar(a, ok);
        ar_accept();
        send_beat(32'h3000_0000, 2'b00, 1'b0);
        send_beat(32'h3000_0004, 2'b00, 1'b0);
        i_reset_n = 1'b0;
        #1;
        checks++;
        if ({o_valid, o_arvalid, o_rready, o_exception, o_inst, o_pc, o_mcause} !== 72'h0) begin
            errors++;
            $display("FAIL rst_async: got valid=%b arvalid=%b rready=%b inst=%h pc=%h expected zeros",
                     o_valid, o_arvalid, o_rready, o_inst, o_pc);
        end
        repeat (2) step();
        i_reset_n = 1'b1;
        wait_ar(a, ok);
        checks++;
        if (!ok || a !== 32'h3000_0000) begin
            errors++; $display("FAIL rst_restart: got %h ok=%0d expected 30000000", a, ok);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_flush_mid_burst();
        test_flush_in_ar();
        test_fault();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
